// File: rtl/conv_frame_writer_if.sv
// rtl/conv_frame_writer_if.sv - frame-buffer write port (req/ack) between writer and SDRAM controller
interface conv_frame_writer_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 21
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/conv_frame_writer.sv
// rtl/conv_frame_writer.sv - raster pixel position tracking, FIFO buffering and frame-buffer write drain
module conv_frame_writer #(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 960,
    parameter int DATA_W     = 12,
    parameter int ADDR_W     = 21,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [DATA_W-1:0]     pix_in,
    input  logic                  pix_valid,
    conv_frame_writer_if.master   wr,
    output logic                  frame_done,
    output logic                  overflow,
    output logic                  busy
);
    localparam int COL_W   = $clog2(WIDTH);
    localparam int ROW_W   = $clog2(HEIGHT);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;

    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_last;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    logic              head_last;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    state_t            state;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    // A pixel arriving with frame_start is the first pixel of the new frame.
    assign cur_col  = frame_start ? '0 : col;
    assign cur_row  = frame_start ? '0 : row;
    assign cur_addr = frame_start ? '0 : addr;
    assign cur_last = (cur_col == COL_LAST) && (cur_row == ROW_LAST);

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign push  = pix_valid && !full;
    assign pop   = !empty && ((state == S_IDLE) || (state == S_REQ && wr.wr_ack));

    assign {head_last, head_addr, head_data} = mem[rd_ptr];

    // Position advances on dropped pixels too, so later pixels keep their geometry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (pix_valid) begin
            col  <= (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
            if (cur_col == COL_LAST)
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            else
                row <= cur_row;
            addr <= (cur_addr == ADDR_LAST) ? '0 : cur_addr + 1'b1;
        end else if (frame_start) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (pix_valid && full)
            overflow <= 1'b1;
        else if (frame_start)
            overflow <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cur_last, cur_addr, pix_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Drain FSM: the head entry is moved into the output registers and held until acked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        req_q  <= 1'b1;
                        addr_q <= head_addr;
                        data_q <= head_data;
                        last_q <= head_last;
                        state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (wr.wr_ack) begin
                        frame_done <= last_q;
                        if (!empty) begin
                            addr_q <= head_addr;
                            data_q <= head_data;
                            last_q <= head_last;
                        end else begin
                            req_q <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign wr.wr_req  = req_q;
    assign wr.wr_addr = addr_q;
    assign wr.wr_data = data_q;
    assign busy       = !empty || req_q;
endmodule

// File: tb/tb_conv_frame_writer.sv
// tb/tb_conv_frame_writer.sv - scoreboard bench for conv_frame_writer on a 4x3 frame
module tb_conv_frame_writer;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int DW = 12;
    localparam int AW = 8;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic [DW-1:0] pix_in;
    logic          pix_valid;
    logic          frame_done;
    logic          overflow;
    logic          busy;

    conv_frame_writer_if #(.DATA_W(DW), .ADDR_W(AW)) wr_if ();

    conv_frame_writer #(
        .WIDTH(W), .HEIGHT(H), .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_start(frame_start),
        .pix_in(pix_in),
        .pix_valid(pix_valid),
        .wr(wr_if.master),
        .frame_done(frame_done),
        .overflow(overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            last;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   model_addr = 0;
    int   pushes = 0;
    int   acks = 0;
    int   done_cnt = 0;
    bit   done_pending = 0;
    bit   prev_hold = 0;
    logic [AW-1:0] held_addr;
    logic [DW-1:0] held_data;
    int   ack_mode = 1;
    int   d0;
    int   base_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle of stimulus; the expected entry is queued when the pixel should be stored.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit fs, input bit store);
        @(posedge clk); #1;
        pix_valid   = v;
        pix_in      = d;
        frame_start = fs;
        if (fs) model_addr = 0;
        if (v) begin
            if (store) begin
                sb.push_back('{last: (model_addr == N - 1), addr: AW'(model_addr), data: d});
                pushes++;
            end
            model_addr = (model_addr == N - 1) ? 0 : model_addr + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Sends only when fewer than D writes are outstanding, so the FIFO can never be full.
    task automatic send(input logic [DW-1:0] d, input bit fs);
        int w = 0;
        while ((pushes - acks) >= D && w < 500) begin
            idle(1);
            w++;
        end
        if (w >= 500) check("send_wait_timeout", 1, 0);
        step(1'b1, d, fs, 1'b1);
    endtask

    task automatic drain();
        int w = 0;
        while ((sb.size() != 0 || wr_if.wr_req) && w < 1000) begin
            idle(1);
            w++;
        end
        check("drain_done", (w < 1000), 1);
        idle(2);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (ack_mode)
                0:       wr_if.wr_ack = 1'b0;
                1:       wr_if.wr_ack = 1'b1;
                default: wr_if.wr_ack = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Monitor: inputs and outputs are stable between the rising edges here.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("frame_done", frame_done, done_pending);
                if (frame_done) done_cnt++;
                done_pending = 0;
                if (prev_hold) begin
                    check("req_held", wr_if.wr_req, 1);
                    check("addr_stable", wr_if.wr_addr, held_addr);
                    check("data_stable", wr_if.wr_data, held_data);
                end
                if (wr_if.wr_req && wr_if.wr_ack) begin
                    if (sb.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("wr_addr", wr_if.wr_addr, e.addr);
                        check("wr_data", wr_if.wr_data, e.data);
                        done_pending = e.last;
                    end
                    acks++;
                end
                prev_hold = wr_if.wr_req && !wr_if.wr_ack;
                held_addr = wr_if.wr_addr;
                held_data = wr_if.wr_data;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_in = '0;
        wr_if.wr_ack = 1'b0; ack_mode = 1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_wr_req", wr_if.wr_req, 0);
        check("rst_wr_addr", wr_if.wr_addr, 0);
        check("rst_wr_data", wr_if.wr_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);

        // Latency and one full frame with ack held high
        d0 = done_cnt;
        step(1'b1, 12'd1, 1'b0, 1'b1);
        step(1'b1, 12'd2, 1'b0, 1'b1);
        @(negedge clk);
        check("lat_edge_k", wr_if.wr_req, 0);
        step(1'b1, 12'd3, 1'b0, 1'b1);
        @(negedge clk);
        check("lat_edge_k1", wr_if.wr_req, 1);
        for (int v = 4; v <= 12; v++) step(1'b1, DW'(v), 1'b0, 1'b1);
        drain();
        check("t2_frame_done_cnt", done_cnt - d0, 1);

        // Stall: one write in flight, then 20 pixels with the FIFO unable to drain
        ack_mode = 0;
        idle(2);
        base_addr = model_addr;
        step(1'b1, 12'h700, 1'b0, 1'b1);
        idle(2);
        @(negedge clk);
        check("t3_in_flight", wr_if.wr_req, 1);
        for (int i = 0; i < 20; i++) step(1'b1, DW'(12'h100 + i), 1'b0, (i < 16));
        idle(1);
        @(negedge clk);
        check("t3_overflow", overflow, 1);
        check("t3_busy", busy, 1);
        check("t3_model_addr", model_addr, (base_addr + 21) % N);
        ack_mode = 1;
        drain();
        send(12'h7AB, 1'b0);
        drain();
        check("t3_overflow_sticky", overflow, 1);

        // Reset mid-stream
        ack_mode = 0;
        idle(2);
        send(12'h321, 1'b0);
        send(12'h322, 1'b0);
        idle(3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_req", wr_if.wr_req, 0);
        check("mid_rst_wr_addr", wr_if.wr_addr, 0);
        check("mid_rst_wr_data", wr_if.wr_data, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_busy", busy, 0);
        sb.delete();
        model_addr = 0; pushes = 0; acks = 0;
        done_pending = 0; prev_hold = 0;
        pix_valid = 1'b0; frame_start = 1'b0;
        ack_mode = 1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        send(12'h5A5, 1'b0);
        drain();

        // Overflow and frame_start in the same cycle: set wins, dropped pixel still counts as (0,0)
        ack_mode = 0;
        idle(2);
        step(1'b1, 12'h800, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < D; i++) step(1'b1, DW'(12'h810 + i), 1'b0, 1'b1);
        step(1'b1, 12'h8FF, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        check("t7_overflow_set_wins", overflow, 1);
        ack_mode = 1;
        drain();
        send(12'h901, 1'b0);
        drain();

        // frame_start at column 2 of row 1 while older entries wait in the FIFO
        ack_mode = 0;
        idle(2);
        while (model_addr != W + 2) send(DW'(12'hA00 + model_addr), 1'b0);
        @(negedge clk);
        check("t5_overflow_before", overflow, 1);
        step(1'b1, 12'hB00, 1'b1, 1'b1);
        idle(1);
        @(negedge clk);
        check("t5_overflow_cleared", overflow, 0);
        check("t5_busy", busy, 1);
        send(12'hB01, 1'b0);
        send(12'hB02, 1'b0);
        ack_mode = 1;
        drain();

        // Two frames back to back
        d0 = done_cnt;
        send(12'hC00, 1'b1);
        for (int i = 1; i < 2 * N; i++) send(DW'(12'hC00 + i), 1'b0);
        drain();
        check("t6_frame_done_cnt", done_cnt - d0, 2);

        // Random ack gaps and random pixel gaps over three frames
        ack_mode = 2;
        d0 = done_cnt;
        for (int i = 0; i < 3 * N; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(DW'($urandom_range(0, 4095)), (i == 0));
        end
        ack_mode = 1;
        drain();
        check("t4_frame_done_cnt", done_cnt - d0, 3);
        check("final_busy", busy, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
